// File: rtl/scan_chain_responder_if.sv
// ----------------------------------------------------------------------------
// scan_chain_responder_if
//   Groups the scan pins, the core-facing state/next-state buses and the
//   self-test status outputs of scan_chain_responder into one bundle.
//
//   Signals (directions as seen from the responder, i.e. the slave modport):
//     NbarT      in   1      1 = scan shift, 0 = functional capture
//     Si         in   1      scan serial input
//     So         out  1      scan serial output (last chain bit)
//     d_next     in   FF     functional next state from the core, [1:FF]
//     state_q    out  FF     current state to the core, [1:FF]
//     po         in   PO_W   primary outputs of the core
//     sig        out  PO_W   MISR signature
//     shift_cnt  out  8      length of current/last shift burst
//     cap_cnt    out  CNT_W  capture cycles since reset
//     burst_err  out  1      sticky protocol error flag
//
//   master: the tester / core side that drives mode, scan data and core data.
//   slave : the responder itself.
// ----------------------------------------------------------------------------
interface scan_chain_responder_if #(
  parameter int FF    = 18,
  parameter int PO_W  = 14,
  parameter int CNT_W = 16
);
  logic             NbarT;
  logic             Si;
  logic             So;
  logic [1:FF]      d_next;
  logic [1:FF]      state_q;
  logic [PO_W-1:0]  po;
  logic [PO_W-1:0]  sig;
  logic [7:0]       shift_cnt;
  logic [CNT_W-1:0] cap_cnt;
  logic             burst_err;

  modport master (
    output NbarT, Si, d_next, po,
    input  So, state_q, sig, shift_cnt, cap_cnt, burst_err
  );

  modport slave (
    input  NbarT, Si, d_next, po,
    output So, state_q, sig, shift_cnt, cap_cnt, burst_err
  );
endinterface

// File: rtl/scan_chain_responder.sv
// ----------------------------------------------------------------------------
// scan_chain_responder
//   Device-side end of a full-scan test protocol. Holds the FF-bit state
//   register of a scan-inserted circuit. While NbarT=1 the register shifts
//   Si -> state_q[1] -> ... -> state_q[FF] -> So. While NbarT=0 it captures
//   the core's functional next state and folds the primary outputs into a
//   MISR signature. Shift bursts are measured so that on-chip self-test can
//   confirm a tester loads exactly FF bits between captures.
//
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  synchronous active-high reset (clears every register)
//     bus   scan_chain_responder_if.slave
//             NbarT, Si, d_next, po               -> inputs
//             So, state_q, sig, shift_cnt,
//             cap_cnt, burst_err                  -> registered outputs
//
//   All outputs come straight from flops; there is no combinational path
//   from any input to any output.
// ----------------------------------------------------------------------------
module scan_chain_responder #(
  parameter int              FF        = 18,
  parameter int              PO_W      = 14,
  parameter logic [PO_W-1:0] MISR_POLY = 14'h2011,
  parameter int              CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  scan_chain_responder_if.slave bus
);

  // Mode of the previous edge. Only the transition CAPTURE->SHIFT restarts
  // the burst counter and only SHIFT->CAPTURE ends (and judges) a burst.
  typedef enum logic {
    CAPTURE = 1'b0,
    SHIFT   = 1'b1
  } mode_e;

  mode_e            r_mode;
  mode_e            w_mode_nxt;

  logic [1:FF]      r_state;
  logic [1:FF]      w_state_nxt;
  logic [PO_W-1:0]  r_sig;
  logic [PO_W-1:0]  w_sig_nxt;
  logic [7:0]       r_shift_cnt;
  logic [7:0]       w_shift_cnt_nxt;
  logic [CNT_W-1:0] r_cap_cnt;
  logic [CNT_W-1:0] w_cap_cnt_nxt;
  logic             r_burst_err;
  logic             w_burst_err_nxt;
  logic             w_burst_bad;

  // Burst counter increment, holding at 255 so very long bursts stay
  // visibly "too long" instead of wrapping back to a legal-looking value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    r = (v == 8'hFF) ? v : v + 8'd1;
    return r;
  endfunction

  // Capture counter increment, holding at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // One MISR step: Galois-style shift left, feed the dropped MSB back through
  // the tap mask, then fold in the parallel primary-output word.
  function automatic logic [PO_W-1:0] misr_step(input logic [PO_W-1:0] s,
                                                input logic [PO_W-1:0] p);
    logic [PO_W-1:0] sh;
    sh = {s[PO_W-2:0], 1'b0};
    return sh ^ (s[PO_W-1] ? MISR_POLY : {PO_W{1'b0}}) ^ p;
  endfunction

  // A burst is legal only when exactly FF bits were shifted. Compared at
  // 32 bits so that an FF beyond the counter range can never match a
  // saturated count.
  assign w_burst_bad = ({24'd0, r_shift_cnt} != 32'(FF));

  // Next-state / next-output decode
  always_comb begin
    w_mode_nxt      = CAPTURE;
    w_state_nxt     = r_state;
    w_sig_nxt       = r_sig;
    w_shift_cnt_nxt = r_shift_cnt;
    w_cap_cnt_nxt   = r_cap_cnt;
    w_burst_err_nxt = r_burst_err;

    if (bus.NbarT) begin
      w_mode_nxt  = SHIFT;
      // Index 1 is the leftmost packed bit, so Si enters at state_q[1] and
      // the old state_q[FF] falls off the end (it was already on So).
      w_state_nxt = {bus.Si, r_state[1:FF-1]};
      if (r_mode == CAPTURE) begin
        w_shift_cnt_nxt = 8'd1;
      end else begin
        w_shift_cnt_nxt = sat_inc8(r_shift_cnt);
      end
    end else begin
      w_mode_nxt    = CAPTURE;
      w_state_nxt   = bus.d_next;
      w_sig_nxt     = misr_step(r_sig, bus.po);
      w_cap_cnt_nxt = sat_inc_cnt(r_cap_cnt);
      // shift_cnt is left alone so the length of the burst just ended can
      // still be read. Back-to-back captures never judge a burst.
      if ((r_mode == SHIFT) && w_burst_bad) begin
        w_burst_err_nxt = 1'b1;
      end
    end
  end

  // Register stage: everything, including the scan data, is cleared by rst
  // so that a reset mid-burst discards the partial load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= CAPTURE;
      r_state     <= '0;
      r_sig       <= '0;
      r_shift_cnt <= '0;
      r_cap_cnt   <= '0;
      r_burst_err <= 1'b0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_state     <= w_state_nxt;
      r_sig       <= w_sig_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
      r_cap_cnt   <= w_cap_cnt_nxt;
      r_burst_err <= w_burst_err_nxt;
    end
  end

  // So is the last chain flop itself, so it shows the bit about to leave.
  assign bus.So        = r_state[FF];
  assign bus.state_q   = r_state;
  assign bus.sig       = r_sig;
  assign bus.shift_cnt = r_shift_cnt;
  assign bus.cap_cnt   = r_cap_cnt;
  assign bus.burst_err = r_burst_err;

endmodule

// File: tb/tb_scan_chain_responder.sv
// ----------------------------------------------------------------------------
// tb_scan_chain_responder
//   Directed bench for scan_chain_responder: shift/capture behaviour, scan
//   unload order, MISR arithmetic, burst-length checking, reset mid-burst
//   and counter saturation.
// ----------------------------------------------------------------------------
module tb_scan_chain_responder;
  localparam int FF    = 18;
  localparam int PO_W  = 14;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  scan_chain_responder_if #(.FF(FF), .PO_W(PO_W), .CNT_W(CNT_W)) bus ();

  scan_chain_responder #(
    .FF       (FF),
    .PO_W     (PO_W),
    .MISR_POLY(14'h2011),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.NbarT  = 1'b0;
    bus.Si     = 1'b0;
    bus.d_next = '0;
    bus.po     = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    bus.NbarT = 1'b1;
    bus.Si    = b;
    tick();
  endtask

  task automatic capture(input logic [1:FF] d, input logic [PO_W-1:0] p);
    bus.NbarT  = 1'b0;
    bus.d_next = d;
    bus.po     = p;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    // Load some non-zero state, then reset while shift inputs are active.
    for (int i = 0; i < 7; i++) shift_bit(1'b1);
    capture(18'h3FFFF, 14'h3FFF);
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    rst        = 1'b1;
    bus.NbarT  = 1'b1;
    bus.Si     = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.state_q !== 18'h00000) begin
      miscompares++;
      $display("FAIL reset_state_q: got %h expected %h", bus.state_q, 18'h00000);
    end
    vectors++;
    if (bus.So !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_So: got %b expected 0", bus.So);
    end
    vectors++;
    if (bus.sig !== 14'h0000) begin
      miscompares++;
      $display("FAIL reset_sig: got %h expected 0000", bus.sig);
    end
    vectors++;
    if (bus.shift_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_shift_cnt: got %0d expected 0", bus.shift_cnt);
    end
    vectors++;
    if (bus.cap_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_cap_cnt: got %0d expected 0", bus.cap_cnt);
    end
    vectors++;
    if (bus.burst_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_burst_err: got %b expected 0", bus.burst_err);
    end
  endtask

  task automatic test_shift_ones();
    logic exp_so;
    do_reset();
    for (int i = 1; i <= FF; i++) begin
      shift_bit(1'b1);
      exp_so = (i == FF);
      vectors++;
      if (bus.So !== exp_so) begin
        miscompares++;
        $display("FAIL shift_ones_So edge %0d: got %b expected %b", i, bus.So, exp_so);
      end
    end
    vectors++;
    if (bus.state_q !== 18'h3FFFF) begin
      miscompares++;
      $display("FAIL shift_ones_state_q: got %h expected 3ffff", bus.state_q);
    end
    vectors++;
    if (bus.shift_cnt !== 8'd18) begin
      miscompares++;
      $display("FAIL shift_ones_shift_cnt: got %0d expected 18", bus.shift_cnt);
    end
  endtask

  task automatic test_capture_unload();
    logic [1:FF] v;
    logic [1:FF] got;
    v = 18'h2A5A5;
    do_reset();
    // state_q[FF] bit goes in first, so it travels furthest down the chain.
    for (int i = 0; i < FF; i++) shift_bit(v[FF-i]);
    vectors++;
    if (bus.state_q !== 18'h2A5A5) begin
      miscompares++;
      $display("FAIL load_state_q: got %h expected 2a5a5", bus.state_q);
    end
    capture(18'h00F0F, 14'h0000);
    vectors++;
    if (bus.state_q !== 18'h00F0F) begin
      miscompares++;
      $display("FAIL capture_state_q: got %h expected 00f0f", bus.state_q);
    end
    vectors++;
    if (bus.cap_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL capture_cap_cnt: got %0d expected 1", bus.cap_cnt);
    end
    vectors++;
    if (bus.burst_err !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_burst_err: got %b expected 0", bus.burst_err);
    end
    vectors++;
    if (bus.shift_cnt !== 8'd18) begin
      miscompares++;
      $display("FAIL capture_shift_cnt_hold: got %0d expected 18", bus.shift_cnt);
    end
    // Unload: So shows the bit leaving on the next edge.
    got = '0;
    for (int i = 0; i < FF; i++) begin
      got[FF-i] = bus.So;
      shift_bit(1'b0);
    end
    vectors++;
    if (got !== 18'h00F0F) begin
      miscompares++;
      $display("FAIL unload_stream: got %h expected 00f0f", got);
    end
    vectors++;
    if (bus.state_q !== 18'h00000) begin
      miscompares++;
      $display("FAIL unload_state_q: got %h expected 00000", bus.state_q);
    end
  endtask

  task automatic test_burst_err();
    do_reset();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    capture(18'h0, 14'h0);
    vectors++;
    if (bus.burst_err !== 1'b1) begin
      miscompares++;
      $display("FAIL short_burst_err: got %b expected 1", bus.burst_err);
    end
    vectors++;
    if (bus.shift_cnt !== 8'd5) begin
      miscompares++;
      $display("FAIL short_burst_shift_cnt: got %0d expected 5", bus.shift_cnt);
    end
    for (int i = 0; i < FF; i++) shift_bit(1'b0);
    capture(18'h0, 14'h0);
    for (int i = 0; i < FF; i++) shift_bit(1'b1);
    capture(18'h0, 14'h0);
    vectors++;
    if (bus.burst_err !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky_burst_err: got %b expected 1", bus.burst_err);
    end
    do_reset();
    vectors++;
    if (bus.burst_err !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_err_clear: got %b expected 0", bus.burst_err);
    end
  endtask

  task automatic test_misr();
    do_reset();
    capture(18'h0, 14'h0001);
    vectors++;
    if (bus.sig !== 14'h0001) begin
      miscompares++;
      $display("FAIL misr_1: got %h expected 0001", bus.sig);
    end
    capture(18'h0, 14'h0000);
    vectors++;
    if (bus.sig !== 14'h0002) begin
      miscompares++;
      $display("FAIL misr_2: got %h expected 0002", bus.sig);
    end
    // 0002<<1 = 0004; 0004 ^ 2004 = 2000.
    capture(18'h0, 14'h2004);
    vectors++;
    if (bus.sig !== 14'h2000) begin
      miscompares++;
      $display("FAIL misr_preset: got %h expected 2000", bus.sig);
    end
    // MSB set: shifted 0000 ^ poly 2011.
    capture(18'h0, 14'h0000);
    vectors++;
    if (bus.sig !== 14'h2011) begin
      miscompares++;
      $display("FAIL misr_feedback: got %h expected 2011", bus.sig);
    end
    // 2011<<1 = 0022 (14 bits); ^2011 = 2033.
    capture(18'h0, 14'h0000);
    vectors++;
    if (bus.sig !== 14'h2033) begin
      miscompares++;
      $display("FAIL misr_feedback2: got %h expected 2033", bus.sig);
    end
    vectors++;
    if (bus.cap_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL misr_cap_cnt: got %0d expected 5", bus.cap_cnt);
    end
    for (int i = 0; i < FF; i++) shift_bit(1'b1);
    vectors++;
    if (bus.sig !== 14'h2033) begin
      miscompares++;
      $display("FAIL misr_hold_on_shift: got %h expected 2033", bus.sig);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 8; i++) shift_bit(1'b1);
    // Edge 9 of the burst comes with reset asserted.
    rst       = 1'b1;
    bus.NbarT = 1'b1;
    bus.Si    = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.state_q !== 18'h00000) begin
      miscompares++;
      $display("FAIL midrst_state_q: got %h expected 00000", bus.state_q);
    end
    vectors++;
    if (bus.shift_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL midrst_shift_cnt: got %0d expected 0", bus.shift_cnt);
    end
    for (int i = 0; i < FF; i++) shift_bit(1'b0);
    vectors++;
    if (bus.shift_cnt !== 8'd18) begin
      miscompares++;
      $display("FAIL midrst_new_burst_cnt: got %0d expected 18", bus.shift_cnt);
    end
    capture(18'h0, 14'h0);
    vectors++;
    if (bus.burst_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_burst_err: got %b expected 0", bus.burst_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) capture(18'h0, 14'h0);
    vectors++;
    if (bus.cap_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL b2b_cap_cnt: got %0d expected 3", bus.cap_cnt);
    end
    vectors++;
    if (bus.burst_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_burst_err: got %b expected 0", bus.burst_err);
    end
    for (int i = 0; i < FF + 1; i++) shift_bit(1'b0);
    vectors++;
    if (bus.burst_err !== 1'b0) begin
      miscompares++;
      $display("FAIL long_in_progress_err: got %b expected 0", bus.burst_err);
    end
    capture(18'h0, 14'h0);
    vectors++;
    if (bus.burst_err !== 1'b1) begin
      miscompares++;
      $display("FAIL long_burst_err: got %b expected 1", bus.burst_err);
    end
    vectors++;
    if (bus.shift_cnt !== 8'd19) begin
      miscompares++;
      $display("FAIL long_burst_shift_cnt: got %0d expected 19", bus.shift_cnt);
    end
  endtask

  task automatic test_shift_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) shift_bit(1'b0);
    vectors++;
    if (bus.shift_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL shift_cnt_sat: got %0d expected 255", bus.shift_cnt);
    end
    capture(18'h0, 14'h0);
    vectors++;
    if (bus.burst_err !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_burst_err: got %b expected 1", bus.burst_err);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.NbarT   = 1'b0;
    bus.Si      = 1'b0;
    bus.d_next  = '0;
    bus.po      = '0;

    test_reset();
    test_shift_ones();
    test_capture_unload();
    test_burst_err();
    test_misr();
    test_reset_mid_burst();
    test_back_to_back();
    test_shift_saturation();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
